// File: rtl/uart_prog_loader_pkg.sv
// Shared configuration for the UART program loader: default line settings,
// RAM address width and the receive FSM state encodings.
package uart_prog_loader_pkg;

    localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;
    localparam int unsigned DEFAULT_BAUD     = 115_200;
    localparam int unsigned ADDR_W           = 16;
    localparam int unsigned DATA_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } uart_state_e;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-RAM byte-write port driven by the loader.
// Handshake: uart_done is a one-cycle strobe; buffer and data_addr are valid while it is high (no back-pressure).
interface uart_prog_loader_if;
    import uart_prog_loader_pkg::*;

    logic              uart_done;
    logic [DATA_W-1:0] buffer;
    logic [ADDR_W-1:0] data_addr;

    modport master (output uart_done, output buffer, output data_addr);
    modport slave  (input  uart_done, input  buffer, input  data_addr);

endinterface

// File: rtl/uart_prog_loader_baud_gen.sv
// Reloadable baud down-counter: load_half arms a half-bit delay, after which
// tick fires once per full bit period while run is held.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic load_half,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = run && (cnt_q == '0);
        if (load_half) begin
            cnt_d = HALF_RELOAD;
        end else if (run) begin
            if (cnt_q == '0) cnt_d = FULL_RELOAD;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: 8N1 receiver that writes each good byte into the
// instruction RAM at an auto-incrementing address and tracks the load session.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD         = DEFAULT_BAUD,
    parameter int unsigned IDLE_TIMEOUT = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    input  logic                addr_clr,
    uart_prog_loader_if.master  wr,
    output logic                frame_err,
    output logic                load_active,
    output logic                load_done,
    output uart_state_e         state_dbg
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned TIMEOUT_CYC  = IDLE_TIMEOUT * CLKS_PER_BIT;
    localparam int unsigned IDLE_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] TIMEOUT_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic rx_meta_q, rx_sync_q, rx_prev_q;

    uart_state_e       state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] buffer_q, buffer_d;
    logic              uart_done_q, uart_done_d;
    logic              frame_err_q, frame_err_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic              load_active_q, load_active_d;
    logic              load_done_q, load_done_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    logic load_half, baud_run, baud_tick, start_edge;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk       (clk),
        .rst       (rst),
        .load_half (load_half),
        .run       (baud_run),
        .tick      (baud_tick)
    );

    // Receive FSM: every decision uses the synchronised line.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        buffer_d    = buffer_q;
        uart_done_d = 1'b0;
        frame_err_d = 1'b0;
        load_half   = 1'b0;
        baud_run    = 1'b0;
        start_edge  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    start_edge = 1'b1;
                    load_half  = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                baud_run = 1'b1;
                if (baud_tick) begin
                    if (!rx_sync_q) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                baud_run = 1'b1;
                if (baud_tick) begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                baud_run = 1'b1;
                if (baud_tick) begin
                    if (rx_sync_q) begin
                        buffer_d    = shift_q;
                        uart_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HI;
                    end
                end
            end
            ST_WAIT_HI: begin
                // A held-low break must not be mistaken for a new start bit.
                if (rx_sync_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address counter: clear beats increment; the strobe cycle still shows the old address.
    always_comb begin
        data_addr_d = data_addr_q;
        if (addr_clr)         data_addr_d = '0;
        else if (uart_done_q) data_addr_d = data_addr_q + ADDR_W'(1);
    end

    always_comb begin
        load_active_d = load_active_q;
        load_done_d   = 1'b0;
        idle_cnt_d    = '0;
        if (uart_done_d) begin
            load_active_d = 1'b1;
        end else if (state_q == ST_IDLE && load_active_q && !start_edge) begin
            if (idle_cnt_q == TIMEOUT_LAST) begin
                load_active_d = 1'b0;
                load_done_d   = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_prev_q     <= 1'b1;
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            buffer_q      <= '0;
            uart_done_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            data_addr_q   <= '0;
            load_active_q <= 1'b0;
            load_done_q   <= 1'b0;
            idle_cnt_q    <= '0;
        end else begin
            rx_meta_q     <= rx;
            rx_sync_q     <= rx_meta_q;
            rx_prev_q     <= rx_sync_q;
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_idx_q     <= bit_idx_d;
            buffer_q      <= buffer_d;
            uart_done_q   <= uart_done_d;
            frame_err_q   <= frame_err_d;
            data_addr_q   <= data_addr_d;
            load_active_q <= load_active_d;
            load_done_q   <= load_done_d;
            idle_cnt_q    <= idle_cnt_d;
        end
    end

    assign wr.uart_done = uart_done_q;
    assign wr.buffer    = buffer_q;
    assign wr.data_addr = data_addr_q;
    assign frame_err    = frame_err_q;
    assign load_active  = load_active_q;
    assign load_done    = load_done_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader at a reduced line rate (16 clocks per bit) so that
// every scenario, including the idle timeout, fits a short run.
module tb_uart_prog_loader;
    import uart_prog_loader_pkg::*;

    localparam int unsigned CLK_FREQ     = 1_600_000;
    localparam int unsigned BAUD         = 100_000;
    localparam int unsigned BIT          = 16;
    localparam int unsigned IDLE_TIMEOUT = 20;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        addr_clr;
    logic        frame_err;
    logic        load_active;
    logic        load_done;
    uart_state_e state_dbg;

    uart_prog_loader_if wr_if ();

    uart_prog_loader #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .addr_clr    (addr_clr),
        .wr          (wr_if.master),
        .frame_err   (frame_err),
        .load_active (load_active),
        .load_done   (load_done),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;
    int ferr_cnt  = 0;
    int ld_cnt    = 0;

    logic [23:0] exp_q[$];
    logic [23:0] exp_w;

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx       = 1'b1;
        addr_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    // Called on a negedge; returns on the negedge that ends the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic expect_write(input logic [15:0] addr, input logic [7:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (wr_if.uart_done) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected: got addr %h data %h, expected no write",
                         wr_if.data_addr, wr_if.buffer);
            end else begin
                exp_w = exp_q.pop_front();
                if ({wr_if.data_addr, wr_if.buffer} !== exp_w) begin
                    fails++;
                    $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                             wr_if.data_addr, wr_if.buffer, exp_w[23:8], exp_w[7:0]);
                end
            end
        end
        if (frame_err) ferr_cnt++;
        if (load_done) ld_cnt++;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        addr_clr = 1'b0;

        // 1: reset values, single byte
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst_uart_done",   32'(wr_if.uart_done), 32'd0);
        check("rst_buffer",      32'(wr_if.buffer),    32'h00);
        check("rst_data_addr",   32'(wr_if.data_addr), 32'h0000);
        check("rst_frame_err",   32'(frame_err),       32'd0);
        check("rst_load_active", 32'(load_active),     32'd0);
        check("rst_load_done",   32'(load_done),       32'd0);
        check("rst_state",       32'(state_dbg),       32'(ST_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        expect_write(16'h0000, 8'hA5);
        send_byte(8'hA5, 1'b1);
        check("t1_drain", exp_q.size(), 32'd0);
        check("t1_addr_inc", 32'(wr_if.data_addr), 32'h0001);

        // 2: back-to-back frames from address 0
        do_reset();
        expect_write(16'h0000, 8'h13);
        expect_write(16'h0001, 8'h97);
        expect_write(16'h0002, 8'h00);
        expect_write(16'h0003, 8'h93);
        ferr_cnt = 0;
        send_byte(8'h13, 1'b1);
        send_byte(8'h97, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h93, 1'b1);
        check("t2_drain", exp_q.size(), 32'd0);
        check("t2_no_ferr", 32'(ferr_cnt), 32'd0);

        // 3: bad stop bit, then a long break
        ferr_cnt = 0;
        send_byte(8'h3C, 1'b0);
        check("t3_ferr_once", 32'(ferr_cnt), 32'd1);
        check("t3_addr_kept", 32'(wr_if.data_addr), 32'h0004);
        check("t3_buf_kept",  32'(wr_if.buffer),    32'h93);
        repeat (40 * BIT) @(negedge clk);
        check("t3_wait_hi", 32'(state_dbg), 32'(ST_WAIT_HI));
        check("t3_ferr_still_once", 32'(ferr_cnt), 32'd1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_back_idle", 32'(state_dbg), 32'(ST_IDLE));

        // 4: short glitch rejected, next byte at unchanged address
        repeat (2 * BIT) @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("t4_glitch_idle", 32'(state_dbg), 32'(ST_IDLE));
        expect_write(16'h0004, 8'h55);
        send_byte(8'h55, 1'b1);
        check("t4_drain", exp_q.size(), 32'd0);

        // 5: wrap at FFFF, then addr_clr coinciding with a strobe
        force dut.data_addr_q = 16'hFFFF;
        @(negedge clk);
        release dut.data_addr_q;
        @(negedge clk);
        check("t5_preload", 32'(wr_if.data_addr), 32'hFFFF);
        expect_write(16'hFFFF, 8'h11);
        expect_write(16'h0000, 8'h22);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("t5_wrap_drain", exp_q.size(), 32'd0);
        expect_write(16'h0001, 8'h33);
        expect_write(16'h0000, 8'h44);
        fork
            send_byte(8'h33, 1'b1);
            begin
                int n;
                n = 0;
                while (!wr_if.uart_done && n < 20 * BIT) begin
                    @(negedge clk);
                    n++;
                end
                check("t5_strobe_seen", 32'(n < 20 * BIT), 32'd1);
                addr_clr = 1'b1;
                @(negedge clk);
                addr_clr = 1'b0;
            end
        join
        send_byte(8'h44, 1'b1);
        check("t5_clr_drain", exp_q.size(), 32'd0);

        // 6: load session and idle timeout
        do_reset();
        ld_cnt = 0;
        expect_write(16'h0000, 8'h01);
        expect_write(16'h0001, 8'h80);
        expect_write(16'h0002, 8'hFE);
        send_byte(8'h01, 1'b1);
        check("t6_active_after_b1", 32'(load_active), 32'd1);
        send_byte(8'h80, 1'b1);
        send_byte(8'hFE, 1'b1);
        check("t6_drain", exp_q.size(), 32'd0);
        repeat (IDLE_TIMEOUT * BIT - 40) @(negedge clk);
        check("t6_still_active", 32'(load_active), 32'd1);
        check("t6_no_done_yet", 32'(ld_cnt), 32'd0);
        repeat (80) @(negedge clk);
        check("t6_inactive", 32'(load_active), 32'd0);
        check("t6_done_once", 32'(ld_cnt), 32'd1);
        check("t6_addr_kept", 32'(wr_if.data_addr), 32'h0003);

        // reset in the middle of a frame
        rx = 1'b0;
        repeat (4 * BIT) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_uart_done", 32'(wr_if.uart_done), 32'd0);
        check("t6_rst_buffer",    32'(wr_if.buffer),    32'h00);
        check("t6_rst_data_addr", 32'(wr_if.data_addr), 32'h0000);
        check("t6_rst_state",     32'(state_dbg),       32'(ST_IDLE));
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        check("t6_no_trunc_write", exp_q.size(), 32'd0);
        check("t6_idle_after_rst", 32'(state_dbg), 32'(ST_IDLE));
        expect_write(16'h0000, 8'h5A);
        send_byte(8'h5A, 1'b1);
        check("t6_recover_drain", exp_q.size(), 32'd0);

        // ---------------- report ----------------
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
